// File: rtl/candy_board.sv
// Candy board storage: 8x8 grid of 3-bit colors, LFSR fill after reset, swap and random rewrite.
// Optional CANDY_BOARD_NO_MATCH_EN makes the initial fill avoid row/column triples.
module candy_board #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [2:0] X,
  input  logic [2:0] Y,
  output logic [2:0] ColorXY,
  input  logic       swapFlag,
  input  logic [2:0] swapX,
  input  logic [2:0] swapY,
  input  logic       randFlag,
  input  logic [2:0] rewriteX,
  input  logic [2:0] rewriteY,
  input  logic [2:0] DispX,
  input  logic [2:0] DispY,
  output logic [2:0] DispColor,
  output logic       Busy,
  output logic       SwapDone,
  output logic       RewriteDone
);

  typedef enum logic {StFill, StIdle} state_e;

  state_e      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [5:0]  fill_idx_q;
  logic [2:0]  board_q [64];
  logic [2:0]  rand_color;
  logic [2:0]  fill_color;
  logic [5:0]  addr_a;
  logic [5:0]  addr_b;
  logic [5:0]  addr_r;

  assign ColorXY   = board_q[{Y, X}];
  assign DispColor = board_q[{DispY, DispX}];
  assign addr_a    = {Y, X};
  assign addr_b    = {swapY, swapX};
  assign addr_r    = {rewriteY, rewriteX};

  // Galois LFSR, shift right, taps x^16+x^14+x^13+x^11.
  assign lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign rand_color = (lfsr_q[2:0] < 3'd6) ? lfsr_q[2:0] : lfsr_q[2:0] - 3'd6;

`ifdef CANDY_BOARD_NO_MATCH_EN
  logic [2:0] cand1;
  logic [2:0] cand2;
  logic [2:0] left1;
  logic [2:0] left2;
  logic [2:0] up1;
  logic [2:0] up2;
  logic       row_pair;
  logic       col_pair;

  always_comb begin
    left1    = board_q[fill_idx_q - 6'd1];
    left2    = board_q[fill_idx_q - 6'd2];
    up1      = board_q[fill_idx_q - 6'd8];
    up2      = board_q[fill_idx_q - 6'd16];
    // A pair to the left/above forbids exactly its own color.
    row_pair = (fill_idx_q[2:0] >= 3'd2) && (left1 == left2);
    col_pair = (fill_idx_q[5:3] >= 3'd2) && (up1 == up2);
    cand1    = (rand_color == 3'd5) ? 3'd0 : rand_color + 3'd1;
    cand2    = (cand1 == 3'd5) ? 3'd0 : cand1 + 3'd1;
    if (!((row_pair && rand_color == left1) || (col_pair && rand_color == up1))) begin
      fill_color = rand_color;
    end else if (!((row_pair && cand1 == left1) || (col_pair && cand1 == up1))) begin
      fill_color = cand1;
    end else begin
      fill_color = cand2;
    end
  end
`else
  assign fill_color = rand_color;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StFill;
      lfsr_q      <= SEED;
      fill_idx_q  <= 6'd0;
      Busy        <= 1'b1;
      SwapDone    <= 1'b0;
      RewriteDone <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        board_q[i] <= 3'd0;
      end
    end else if (Enable) begin
      lfsr_q      <= lfsr_d;
      SwapDone    <= 1'b0;
      RewriteDone <= 1'b0;
      unique case (state_q)
        StFill: begin
          board_q[fill_idx_q] <= fill_color;
          fill_idx_q          <= fill_idx_q + 6'd1;
          if (fill_idx_q == 6'd63) begin
            state_q <= StIdle;
            Busy    <= 1'b0;
          end
        end
        StIdle: begin
          if (swapFlag) begin
            board_q[addr_a] <= board_q[addr_b];
            board_q[addr_b] <= board_q[addr_a];
            SwapDone        <= 1'b1;
          end else if (randFlag) begin
            board_q[addr_r] <= rand_color;
            RewriteDone     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end else begin
      SwapDone    <= 1'b0;
      RewriteDone <= 1'b0;
    end
  end

endmodule

// File: tb/tb_candy_board.sv
// Self-checking bench for candy_board: fill length/content, swap, rewrite, enable and reset corners.
module tb_candy_board;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b1;
  logic [2:0] X = 3'd0, Y = 3'd0, swapX = 3'd0, swapY = 3'd0;
  logic [2:0] rewriteX = 3'd0, rewriteY = 3'd0, DispX = 3'd0, DispY = 3'd0;
  logic       swapFlag = 1'b0, randFlag = 1'b0;
  logic [2:0] ColorXY, DispColor;
  logic       Busy, SwapDone, RewriteDone;

  candy_board #(.SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .X(X), .Y(Y), .ColorXY(ColorXY),
    .swapFlag(swapFlag), .swapX(swapX), .swapY(swapY), .randFlag(randFlag),
    .rewriteX(rewriteX), .rewriteY(rewriteY), .DispX(DispX), .DispY(DispY),
    .DispColor(DispColor), .Busy(Busy), .SwapDone(SwapDone), .RewriteDone(RewriteDone)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] ml;
  logic [2:0]  mb [64];

  typedef struct {
    logic       en, sw, rd;
    logic [2:0] x, y, sx, sy, rx, ry;
    logic       exp_sd, exp_rd;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] map_c(input logic [15:0] l);
    logic [2:0] r;
    r = l[2:0];
    return (r < 3'd6) ? r : r - 3'd6;
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Freezes the board with Enable low and compares every cell against the model.
  task automatic check_board(input string name);
    int errs, first, act;
    logic en_save;
    en_save = Enable;
    Enable = 1'b0;
    errs = 0;
    first = -1;
    act = 0;
    for (int i = 0; i < 64; i++) begin
      DispX = i[2:0];
      DispY = i[5:3];
      #1;
      if (DispColor !== mb[i] || DispColor > 3'd5) begin
        if (first < 0) begin
          first = i;
          act = int'(DispColor);
        end
        errs++;
      end
    end
    check({name, "_mismatched_cells"}, errs, 0);
    if (first >= 0) $display("  first bad cell %0d got %0d expected %0d", first, act, mb[first]);
    Enable = en_save;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    ml = 16'hACE1;
    for (int i = 0; i < 64; i++) mb[i] = 3'd0;
  endtask

  // Runs the fill to completion, optionally poking requests while Busy.
  task automatic run_fill(input bit inject);
    int n;
    n = 0;
    while (Busy && n < 100) begin
      if (inject && n == 10) begin
        X = 3'd0; Y = 3'd0; swapX = 3'd1; swapY = 3'd0;
        rewriteX = 3'd0; rewriteY = 3'd0;
        swapFlag = 1'b1; randFlag = 1'b1;
      end
      @(posedge Clk);
      #1;
      swapFlag = 1'b0;
      randFlag = 1'b0;
      if (n < 64) mb[n] = map_c(ml);
      ml = adv(ml);
      n++;
    end
    check("busy_length", n, 64);
`ifdef CANDY_BOARD_NO_MATCH_EN
    begin
      logic [2:0] a [64];
      int trip;
      Enable = 1'b0;
      trip = 0;
      for (int i = 0; i < 64; i++) begin
        DispX = i[2:0]; DispY = i[5:3];
        #1;
        a[i] = DispColor;
        mb[i] = DispColor;
      end
      for (int i = 0; i < 64; i++) begin
        if (i % 8 >= 2 && a[i] == a[i-1] && a[i] == a[i-2]) trip++;
        if (i >= 16 && a[i] == a[i-8] && a[i] == a[i-16]) trip++;
      end
      check("no_match_triples", trip, 0);
      Enable = 1'b1;
    end
`endif
    check_board("fill");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};  // swap (0,0)<->(1,0)
    vecs[1] = '{1, 1, 0, 4, 4, 4, 4, 0, 0, 1, 0};  // self swap
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0, 3, 5, 0, 1};  // rewrite cell 43
    vecs[3] = '{0, 0, 1, 0, 0, 0, 0, 3, 5, 0, 0};  // rewrite while disabled
    vecs[4] = '{1, 1, 1, 2, 2, 7, 7, 6, 1, 1, 0};  // swap wins over rewrite
    vecs[5] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // idle cycle
    vecs[6] = '{0, 1, 0, 5, 0, 0, 5, 0, 0, 0, 0};  // swap while disabled
    vecs[7] = '{1, 0, 1, 0, 0, 0, 0, 7, 7, 0, 1};  // rewrite corner cell 63

    @(posedge Clk);
    do_reset();
    check("reset_busy", int'(Busy), 1);
    check("reset_swapdone", int'(SwapDone), 0);
    check("reset_rewritedone", int'(RewriteDone), 0);
    check_board("reset");
    Enable = 1'b1;
    check("cell0_first_color", int'(map_c(ml)), 1);
    run_fill(1'b1);
    X = 3'd0; Y = 3'd0;
    #1;
    check("colorxy_cell0", int'(ColorXY), int'(mb[0]));

    for (int v = 0; v < 8; v++) begin
      Enable = vecs[v].en;
      swapFlag = vecs[v].sw; randFlag = vecs[v].rd;
      X = vecs[v].x; Y = vecs[v].y; swapX = vecs[v].sx; swapY = vecs[v].sy;
      rewriteX = vecs[v].rx; rewriteY = vecs[v].ry;
      @(posedge Clk);
      #1;
      swapFlag = 1'b0; randFlag = 1'b0;
      if (vecs[v].en) begin
        if (vecs[v].sw) begin
          logic [2:0] t;
          t = mb[{vecs[v].y, vecs[v].x}];
          mb[{vecs[v].y, vecs[v].x}] = mb[{vecs[v].sy, vecs[v].sx}];
          mb[{vecs[v].sy, vecs[v].sx}] = t;
        end else if (vecs[v].rd) begin
          mb[{vecs[v].ry, vecs[v].rx}] = map_c(ml);
        end
        ml = adv(ml);
      end
      check($sformatf("vec%0d_swapdone", v), int'(SwapDone), int'(vecs[v].exp_sd));
      check($sformatf("vec%0d_rewritedone", v), int'(RewriteDone), int'(vecs[v].exp_rd));
      check($sformatf("vec%0d_colorxy", v), int'(ColorXY), int'(mb[{vecs[v].y, vecs[v].x}]));
      check_board($sformatf("vec%0d", v));
      Enable = 1'b1;
    end

    // Done pulse lasts one cycle only.
    rewriteX = 3'd1; rewriteY = 3'd1; randFlag = 1'b1;
    @(posedge Clk);
    #1;
    randFlag = 1'b0;
    mb[9] = map_c(ml);
    ml = adv(ml);
    check("pulse_first", int'(RewriteDone), 1);
    @(posedge Clk);
    #1;
    ml = adv(ml);
    check("pulse_cleared", int'(RewriteDone), 0);

    // Back-to-back rewrite then swap on consecutive edges.
    rewriteX = 3'd0; rewriteY = 3'd7; randFlag = 1'b1;
    @(posedge Clk);
    #1;
    mb[56] = map_c(ml);
    ml = adv(ml);
    check("b2b_rewritedone", int'(RewriteDone), 1);
    randFlag = 1'b0; swapFlag = 1'b1;
    X = 3'd0; Y = 3'd7; swapX = 3'd7; swapY = 3'd0;
    @(posedge Clk);
    #1;
    swapFlag = 1'b0;
    begin
      logic [2:0] t;
      t = mb[56]; mb[56] = mb[7]; mb[7] = t;
    end
    ml = adv(ml);
    check("b2b_swapdone", int'(SwapDone), 1);
    check("b2b_rewrite_cleared", int'(RewriteDone), 0);
    check_board("b2b");

    // Reset at fill index 30 restarts the whole fill.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk);
      #1;
    end
    check("midfill_busy_before", int'(Busy), 1);
    do_reset();
    check("midfill_busy_after", int'(Busy), 1);
    check_board("midfill_reset");
    Enable = 1'b1;
    run_fill(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
